// File: rtl/exp_pkg.sv
// rtl/exp_pkg.sv - shared state encoding and fixed-point widths for the e^x series engine
package exp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // 1.0 in Q1.15, the starting power x^0
  localparam logic [15:0] ONE_Q15 = 16'h8000;
  localparam int P_W    = 16;
  localparam int ACC_W  = 19;
  localparam int TERM_W = 17;

endpackage

// File: rtl/exp_term_unit.sv
// rtl/exp_term_unit.sv - one series step: next power of x and the weighted term (EXP_ROUND_EN selects rounding)
module exp_term_unit
  import exp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [P_W-1:0]    p,
  input  logic [7:0]        x,
  input  logic [DATA_W-1:0] coef,
  output logic [P_W-1:0]    p_next,
  output logic [TERM_W-1:0] term
);

  localparam int PX_W = P_W + 8;
  localparam int PC_W = P_W + DATA_W;

`ifdef EXP_ROUND_EN
  // half an LSB of each result, added before the shift
  localparam logic [PX_W-1:0] P_RND = PX_W'(1) << 7;
  localparam logic [PC_W-1:0] T_RND = PC_W'(1) << (DATA_W - 2);
`else
  localparam logic [PX_W-1:0] P_RND = '0;
  localparam logic [PC_W-1:0] T_RND = '0;
`endif

  logic [PX_W-1:0] px;
  logic [PC_W-1:0] pc;

  assign px = PX_W'(p) * PX_W'(x) + P_RND;
  assign pc = PC_W'(p) * PC_W'(coef) + T_RND;

  // Q1.15 * Q0.8 -> drop 8 fraction bits; Q1.15 * Q1.7 -> drop 7
  assign p_next = px[PX_W-1:8];
  assign term   = pc[PC_W-1:DATA_W-1];

endmodule

// File: rtl/exp_series_engine.sv
// rtl/exp_series_engine.sv - sequential Taylor evaluator for e^x driving a coefficient LUT (optional EXP_ROUND_EN)
module exp_series_engine
  import exp_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        x_in,
  output logic [ADDR_W-1:0] lut_addr,
  input  logic [DATA_W-1:0] lut_data,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result
);

  localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(N_TERMS - 1);

  state_t             state, state_next;
  logic [7:0]         x_q;
  logic [P_W-1:0]     p_q;
  logic [P_W-1:0]     p_next;
  logic [TERM_W-1:0]  term;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_next;
  logic [ADDR_W-1:0]  i_q;
  logic               last_term;

  exp_term_unit #(
    .DATA_W(DATA_W)
  ) u_term (
    .p      (p_q),
    .x      (x_q),
    .coef   (lut_data),
    .p_next (p_next),
    .term   (term)
  );

  assign last_term = (i_q == LAST_I);
  assign acc_next  = acc_q + ACC_W'(term);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    lut_addr   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
        end
      end
      CALC: begin
        busy     = 1'b1;
        lut_addr = i_q;
        if (last_term) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      p_q    <= '0;
      acc_q  <= '0;
      i_q    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_q   <= x_in;
            p_q   <= ONE_Q15;
            acc_q <= '0;
            i_q   <= '0;
          end
        end
        CALC: begin
          acc_q <= acc_next;
          p_q   <= p_next;
          i_q   <= last_term ? '0 : i_q + ADDR_W'(1);
          // capture the final sum on the edge that enters DONE
          if (last_term) begin
            result <= acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
